// File: rtl/id_issue_ctrl_pkg.sv
// Shared decode-stage definitions: opcode encodings, FSM state encoding,
// source-register request payload and instruction field helpers.
package id_issue_ctrl_pkg;

    localparam int unsigned ILEN   = 32;
    localparam int unsigned RIDX_W = 5;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_STALL = 2'd2
    } id_state_e;

    // Source operands an instruction reads, as presented to the scoreboard
    typedef struct packed {
        logic              rs1_en;
        logic [RIDX_W-1:0] rs1;
        logic              rs2_en;
        logic [RIDX_W-1:0] rs2;
    } src_req_t;

    function automatic logic [RIDX_W-1:0] rd_f(input logic [ILEN-1:0] instr);
        return instr[11:7];
    endfunction

    function automatic logic is_load_f(input logic [ILEN-1:0] instr);
        return instr[6:0] == OPC_LOAD;
    endfunction

    // Which register sources the opcode actually reads; unknown opcodes read none
    function automatic src_req_t src_req_f(input logic [ILEN-1:0] instr);
        src_req_t r;
        r.rs1    = instr[19:15];
        r.rs2    = instr[24:20];
        r.rs1_en = 1'b0;
        r.rs2_en = 1'b0;
        case (instr[6:0])
            OPC_R, OPC_STORE, OPC_BRANCH: begin
                r.rs1_en = 1'b1;
                r.rs2_en = 1'b1;
            end
            OPC_IMM, OPC_LOAD, OPC_JALR: begin
                r.rs1_en = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                r.rs1_en = 1'b0;
            end
            default: begin
                r.rs1_en = 1'b0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/id_issue_ctrl_scoreboard.sv
// Outstanding-load register scoreboard with a two-source hazard query.
// Ports:
//   clk, rst             core clock, synchronous active-high reset
//   set_en, set_idx      mark a register as pending (load issued)
//   clr_en, clr_idx      release a register (load writeback)
//   cur_req              sources of the held instruction, checked against
//                        the current scoreboard view -> hazard_cur_c
//   nxt_req              sources checked against next cycle's scoreboard
//                        -> hazard_nxt_c (used for state selection)
// Optional feature macro: ID_WB_BYPASS_EN (current view ignores the register
// being written back this cycle).
module id_issue_ctrl_scoreboard
    import id_issue_ctrl_pkg::*;
#(
    parameter int unsigned NREG = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [RIDX_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [RIDX_W-1:0] clr_idx,
    input  src_req_t          cur_req,
    input  src_req_t          nxt_req,
    output logic              hazard_cur_c,
    output logic              hazard_nxt_c
);

    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] view_cur;

    function automatic logic hit_f(input src_req_t r, input logic [NREG-1:0] v);
        return (r.rs1_en & v[r.rs1]) | (r.rs2_en & v[r.rs2]);
    endfunction

    // Set is applied after clear so a same-cycle reissue stays pending; x0 never tracked
    always_comb begin
        set_mask = set_en ? (NREG'(1) << set_idx) : '0;
        clr_mask = clr_en ? (NREG'(1) << clr_idx) : '0;
        sb_d     = ((sb_q & ~clr_mask) | set_mask) & ~NREG'(1);
`ifdef ID_WB_BYPASS_EN
        view_cur = sb_q & ~clr_mask;
`else
        view_cur = sb_q;
`endif
        hazard_cur_c = hit_f(cur_req, view_cur);
        hazard_nxt_c = hit_f(nxt_req, sb_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: one-entry decode register, load-use hazard
// stall via the register scoreboard, valid/ready issue to execute, flush.
// Ports:
//   clk, rst                       core clock, synchronous active-high reset
//   if_valid/if_instr/if_pc        fetch offer;  if_ready  decode can accept
//   id_valid/id_instr/id_pc        issue offer;  ex_ready  execute accepts
//   ex_flush                       discard held and incoming instruction
//   wb_valid/wb_rd                 load writeback releases a register
//   id_stall                       held instruction blocked by a hazard
// Optional feature macro: ID_WB_BYPASS_EN (dependent instruction may issue in
// the same cycle as its load's writeback).
module id_issue_ctrl
    import id_issue_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [ILEN-1:0]   if_instr,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_ready,
    output logic              id_valid,
    output logic [ILEN-1:0]   id_instr,
    output logic [XLEN-1:0]   id_pc,
    input  logic              ex_ready,
    input  logic              ex_flush,
    input  logic              wb_valid,
    input  logic [RIDX_W-1:0] wb_rd,
    output logic              id_stall
);

    id_state_e         state_q;
    id_state_e         state_d;
    logic [ILEN-1:0]   instr_q;
    logic [ILEN-1:0]   instr_d;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_d;

    src_req_t          held_req;
    src_req_t          in_req;
    src_req_t          nxt_req;
    logic              hazard_cur;
    logic              hazard_nxt;
    logic              issuable;
    logic              fire;
    logic              capture;
    logic              sb_set;

    assign held_req = src_req_f(instr_q);
    assign in_req   = src_req_f(if_instr);
    // A newly captured instruction is judged on its own sources; otherwise the held one
    assign nxt_req  = capture ? in_req : held_req;
    assign sb_set   = fire & is_load_f(instr_q) & (rd_f(instr_q) != '0);

    id_issue_ctrl_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .set_en       (sb_set),
        .set_idx      (rd_f(instr_q)),
        .clr_en       (wb_valid),
        .clr_idx      (wb_rd),
        .cur_req      (held_req),
        .nxt_req      (nxt_req),
        .hazard_cur_c (hazard_cur),
        .hazard_nxt_c (hazard_nxt)
    );

    // Handshake, stall indication and next-state selection
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
`ifdef ID_WB_BYPASS_EN
        issuable = ((state_q == ST_HOLD) | (state_q == ST_STALL)) & ~hazard_cur & ~ex_flush;
        id_stall = ((state_q == ST_HOLD) | (state_q == ST_STALL)) & hazard_cur;
`else
        issuable = (state_q == ST_HOLD) & ~hazard_cur & ~ex_flush;
        id_stall = (state_q == ST_STALL) | ((state_q == ST_HOLD) & hazard_cur);
`endif
        fire     = issuable & ex_ready;
        if_ready = ((state_q == ST_EMPTY) & ~ex_flush) | fire;
        capture  = if_valid & if_ready;
        id_valid = issuable;

        if (capture) begin
            instr_d = if_instr;
            pc_d    = if_pc;
        end

        if (ex_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (capture) state_d = hazard_nxt ? ST_STALL : ST_HOLD;
                end
                ST_HOLD, ST_STALL: begin
                    if (fire) begin
                        if (capture) state_d = hazard_nxt ? ST_STALL : ST_HOLD;
                        else         state_d = ST_EMPTY;
                    end else if (state_q == ST_STALL && !hazard_nxt) begin
                        state_d = ST_HOLD;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign id_instr = instr_q;
    assign id_pc    = pc_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed self-checking bench for id_issue_ctrl (default build).
module tb_id_issue_ctrl;

    localparam int unsigned XLEN = 32;

    localparam logic [31:0] I_ADDI_X1 = 32'h0050_0093;
    localparam logic [31:0] I_LW_X5   = 32'h0001_2283;
    localparam logic [31:0] I_ADD_X6  = 32'h0012_8333; // add x6,x5,x1
    localparam logic [31:0] I_LW_X0   = 32'h0001_2003;
    localparam logic [31:0] I_ADD_00  = 32'h0000_0333; // add x6,x0,x0
    localparam logic [31:0] I_LW_X7   = 32'h0001_2383;
    localparam logic [31:0] I_ADD_X8  = 32'h0003_8433; // add x8,x7,x0

    logic            clk = 1'b0;
    logic            rst;
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            if_ready;
    logic            id_valid;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;
    logic            ex_ready;
    logic            ex_flush;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic            id_stall;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_issue_ctrl #(.XLEN(XLEN), .NREG(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_valid (if_valid),
        .if_instr (if_instr),
        .if_pc    (if_pc),
        .if_ready (if_ready),
        .id_valid (id_valid),
        .id_instr (id_instr),
        .id_pc    (id_pc),
        .ex_ready (ex_ready),
        .ex_flush (ex_flush),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .id_stall (id_stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_valid = 1'b0; if_instr = 32'h0; if_pc = '0;
        ex_ready = 1'b1; ex_flush = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick(); tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rst_id_valid got %b want 0", id_valid); end
        n_cmp++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL rst_id_stall got %b want 0", id_stall); end
        n_cmp++; if (id_instr !== 32'h0000_0013) begin n_err++; $display("FAIL rst_id_instr got %h want 00000013", id_instr); end
        n_cmp++; if (id_pc !== '0) begin n_err++; $display("FAIL rst_id_pc got %h want 0", id_pc); end
        n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL rst_if_ready got %b want 1", if_ready); end
    endtask

    task automatic test_addi();
        if_valid = 1'b1; if_instr = I_ADDI_X1; if_pc = 32'h100; ex_ready = 1'b1;
        #1;
        n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL addi_if_ready got %b want 1", if_ready); end
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL addi_pre_valid got %b want 0", id_valid); end
        tick();
        if_valid = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid got %b want 1", id_valid); end
        n_cmp++; if (id_instr !== I_ADDI_X1) begin n_err++; $display("FAIL addi_instr got %h want %h", id_instr, I_ADDI_X1); end
        n_cmp++; if (id_pc !== 32'h100) begin n_err++; $display("FAIL addi_pc got %h want 100", id_pc); end
        tick();
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL addi_post_valid got %b want 0", id_valid); end
    endtask

    task automatic test_load_use();
        if_valid = 1'b1; if_instr = I_LW_X5; if_pc = 32'h200;
        tick();
        if_instr = I_ADD_X6; if_pc = 32'h204;
        #1;
        n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL lu_lw_valid got %b want 1", id_valid); end
        n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL lu_lw_if_ready got %b want 1", if_ready); end
        tick();
        if_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (id_stall !== 1'b1 || id_valid !== 1'b0) begin n_err++; $display("FAIL lu_stall[%0d] got stall=%b valid=%b want 1/0", i, id_stall, id_valid); end
            n_cmp++; if (if_ready !== 1'b0) begin n_err++; $display("FAIL lu_if_ready[%0d] got %b want 0", i, if_ready); end
            tick();
        end
        n_cmp++; if (id_instr !== I_ADD_X6) begin n_err++; $display("FAIL lu_held got %h want %h", id_instr, I_ADD_X6); end
        wb_valid = 1'b1; wb_rd = 5'd5;
        #1;
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL lu_wb_cycle_valid got %b want 0", id_valid); end
        tick();
        wb_valid = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b1 || id_stall !== 1'b0) begin n_err++; $display("FAIL lu_release got valid=%b stall=%b want 1/0", id_valid, id_stall); end
        n_cmp++; if (id_pc !== 32'h204) begin n_err++; $display("FAIL lu_pc got %h want 204", id_pc); end
        tick();
    endtask

    task automatic test_x0_load();
        if_valid = 1'b1; if_instr = I_LW_X0; if_pc = 32'h280;
        tick();
        if_instr = I_ADD_00; if_pc = 32'h284;
        tick();
        if_valid = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b1 || id_stall !== 1'b0) begin n_err++; $display("FAIL x0_no_stall got valid=%b stall=%b want 1/0", id_valid, id_stall); end
        tick();
    endtask

    task automatic test_hold();
        if_valid = 1'b1; if_instr = I_ADDI_X1; if_pc = 32'h300; ex_ready = 1'b0;
        tick();
        if_instr = I_ADD_00; if_pc = 32'h400;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (id_instr !== I_ADDI_X1 || id_pc !== 32'h300) begin n_err++; $display("FAIL hold_stable[%0d] got %h/%h want %h/300", i, id_instr, id_pc, I_ADDI_X1); end
            n_cmp++; if (if_ready !== 1'b0 || id_valid !== 1'b1) begin n_err++; $display("FAIL hold_hs[%0d] got ready=%b valid=%b want 0/1", i, if_ready, id_valid); end
            tick();
        end
        if_valid = 1'b0; ex_ready = 1'b1;
        #1;
        n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL hold_issue got %b want 1", id_valid); end
        tick();
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL hold_single got %b want 0", id_valid); end
    endtask

    task automatic test_flush();
        if_valid = 1'b1; if_instr = I_LW_X5; if_pc = 32'h500;
        tick();
        if_instr = I_ADD_X6; if_pc = 32'h504;
        tick();
        if_instr = I_ADDI_X1; if_pc = 32'h600; ex_flush = 1'b1;
        #1;
        n_cmp++; if (if_ready !== 1'b0 || id_valid !== 1'b0) begin n_err++; $display("FAIL fl_gate got ready=%b valid=%b want 0/0", if_ready, id_valid); end
        tick();
        ex_flush = 1'b0; if_valid = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b0 || id_stall !== 1'b0 || if_ready !== 1'b1) begin n_err++; $display("FAIL fl_empty got valid=%b stall=%b ready=%b want 0/0/1", id_valid, id_stall, if_ready); end
        if_valid = 1'b1; if_instr = I_ADD_X6; if_pc = 32'h700;
        tick();
        if_valid = 1'b0;
        #1;
        n_cmp++; if (id_stall !== 1'b1 || id_valid !== 1'b0) begin n_err++; $display("FAIL fl_sb_kept got stall=%b valid=%b want 1/0", id_stall, id_valid); end
        wb_valid = 1'b1; wb_rd = 5'd5;
        tick();
        wb_valid = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h700) begin n_err++; $display("FAIL fl_release got valid=%b pc=%h want 1/700", id_valid, id_pc); end
        tick();
    endtask

    task automatic test_set_wins();
        if_valid = 1'b1; if_instr = I_LW_X7; if_pc = 32'h800;
        tick();
        if_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd7;
        #1;
        n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL sw_lw_valid got %b want 1", id_valid); end
        tick();
        wb_valid = 1'b0;
        if_valid = 1'b1; if_instr = I_ADD_X8; if_pc = 32'h804;
        tick();
        if_valid = 1'b0;
        #1;
        n_cmp++; if (id_stall !== 1'b1 || id_valid !== 1'b0) begin n_err++; $display("FAIL sw_sb7_set got stall=%b valid=%b want 1/0", id_stall, id_valid); end
        wb_valid = 1'b1; wb_rd = 5'd7;
        tick();
        wb_valid = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL sw_release got %b want 1", id_valid); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [4];
        seq[0] = 32'h0050_0093; seq[1] = 32'h0050_0113;
        seq[2] = 32'h0050_0193; seq[3] = 32'h0050_0213;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                if_valid = 1'b1; if_instr = seq[k]; if_pc = 32'h900 + 32'(4 * k);
            end else begin
                if_valid = 1'b0;
            end
            #1;
            if (k > 0) begin
                n_cmp++; if (id_valid !== 1'b1 || id_instr !== seq[k-1]) begin n_err++; $display("FAIL b2b_issue[%0d] got valid=%b instr=%h want 1/%h", k, id_valid, id_instr, seq[k-1]); end
                n_cmp++; if (id_pc !== 32'h900 + 32'(4 * (k - 1))) begin n_err++; $display("FAIL b2b_pc[%0d] got %h", k, id_pc); end
            end
            if (k < 4) begin
                n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d] got %b want 1", k, if_ready); end
            end
            tick();
        end
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b want 0", id_valid); end
    endtask

    task automatic test_mid_reset();
        if_valid = 1'b1; if_instr = I_LW_X5; if_pc = 32'hA00;
        tick();
        if_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b0 || id_instr !== 32'h0000_0013 || if_ready !== 1'b1) begin n_err++; $display("FAIL mr_state got valid=%b instr=%h ready=%b want 0/00000013/1", id_valid, id_instr, if_ready); end
        if_valid = 1'b1; if_instr = I_ADD_X6; if_pc = 32'hA04;
        tick();
        if_valid = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b1 || id_stall !== 1'b0) begin n_err++; $display("FAIL mr_sb_clear got valid=%b stall=%b want 1/0", id_valid, id_stall); end
        tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_x0_load();
        test_hold();
        test_flush();
        test_set_wins();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_issue_ctrl.md
# id_issue_ctrl

Decode-stage issue controller for the core pipeline. It holds one fetched instruction in the decode register and tracks outstanding load destinations in a register scoreboard. It stalls on load-use hazards and issues the instruction to execute with a valid/ready handshake. Branch/jump flushes from execute discard the held instruction.

## Interface
Parameters:
- XLEN, 32, instruction and PC width
- NREG, 32, architectural register count; scoreboard width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  fetch offers an instruction
- if_instr  in  32  fetched instruction
- if_pc  in  XLEN  PC of if_instr
- if_ready  out  1  decode register can accept this cycle
- id_valid  out  1  held instruction is issuable (no hazard, not flushed)
- id_instr  out  32  held instruction
- id_pc  out  XLEN  PC of held instruction
- ex_ready  in  1  execute accepts; issue fires on id_valid & ex_ready
- ex_flush  in  1  redirect; discard held and incoming instruction
- wb_valid  in  1  load writeback completes
- wb_rd  in  5  destination of completing load
- id_stall  out  1  held instruction blocked by scoreboard hazard

## Operation
- FSM states: EMPTY, HOLD, STALL. Reset → EMPTY.
- Field extraction: opcode = instr[6:0], rd = [11:7], rs1 = [19:15], rs2 = [24:20].
- rs1 is used for opcodes R (0110011), I-imm (0010011), load (0000011), S (0100011), B (1100011), jalr (1100111).
- rs2 is used for R, S and B.
- Hazard = (rs1 used & sb[rs1]) | (rs2 used & sb[rs2]). Index x0 never counts.
- Scoreboard sb[NREG-1:0]:
  - Set bit rd on issue of a load with rd≠0.
  - Clear bit wb_rd on wb_valid.
  - Set and clear of the same index in one cycle → set wins (a new load is outstanding).
  - Bit 0 is hardwired 0.
- Transitions:
  - EMPTY: if_valid → capture; go HOLD if no hazard, else STALL.
  - HOLD: fire → if if_valid capture next (HOLD/STALL by its hazard), else EMPTY. No fire → stay.
  - STALL: hazard clears (on the next cycle's sb) → HOLD. Otherwise stay.
  - Any state, ex_flush → EMPTY. Incoming instruction dropped, no issue that cycle, sb not cleared (in-flight loads still write back).
- if_ready = (state==EMPTY) | (state==HOLD & ex_ready & ~hazard), gated by ~ex_flush.
- id_valid = (state==HOLD) & ~hazard & ~ex_flush.
- id_stall = (state==STALL) | (state==HOLD & hazard).
- Unknown opcodes: no rs use, no sb set; pass through to execute.

## Timing
- Reset values: state EMPTY; sb all 0; id_valid 0; id_stall 0; id_instr 32'h0000_0013 (nop); id_pc 0; if_ready 1 after reset deassert.
- Capture-to-issue latency is 1 cycle minimum: instruction accepted in cycle N is offered (id_valid) in cycle N+1.
- Back-to-back issue at 1/cycle with no hazards and ex_ready held high.
- Load-use, without ID_WB_BYPASS_EN: a dependent instruction stalls until the cycle after wb_valid for its source.
- id_instr/id_pc stay stable while id_valid & ~ex_ready (handshake hold rule).
- Reset asserted mid-operation: all state returns to reset values next edge; pending loads are forgotten.

## Configuration
- ID_WB_BYPASS_EN defined: hazard check uses sb & ~(wb_valid ? onehot(wb_rd) : 0). A dependent instruction issues in the same cycle as its load's writeback; load-use stall is reduced by 1 cycle.
- ID_WB_BYPASS_EN undefined: hazard uses registered sb only.

## Structure
- Opcode constants (R/I/load/S/B/U/J encodings) and FSM state encodings belong in core_defines.v / the shared core package.
- One sub-module, id_scoreboard, holds sb with set/clear ports, bypass logic and a two-read hazard query.
- The FSM, pipeline register and handshake live in id_issue_ctrl.

## Test plan
- Reset then addi x1,x0,5 (0x00500093) with ex_ready=1 → if_ready=1; id_valid=1 one cycle after capture, id_instr=0x00500093; sb=0.
- lw x5,0(x2) issued, then add x6,x5,x1 → id_stall=1, id_valid=0 until wb_valid,wb_rd=5. Issue occurs the cycle after (same cycle with ID_WB_BYPASS_EN).
- lw x0,0(x2) then add x6,x0,x0 → sb stays 0, no stall.
- HOLD with ex_ready=0 for 3 cycles → id_instr/id_pc constant, if_ready=0. Then ex_ready=1 → single issue.
- ex_flush while STALL with if_valid=1 → next state EMPTY, incoming instruction dropped, sb bit 5 still set.
- Issue lw x7 in the same cycle as wb_valid,wb_rd=7 → sb[7] remains 1.
